serial_add_ctrl: RTL and testbench

Bit-serial adder controller that sequences a single 1-bit full-adder cell (two half adders plus OR) over a WIDTH-bit operand pair, LSB first. It accepts one operation via a valid/ready handshake, runs WIDTH add cycles with a registered carry, then presents the result with a one-cycle done pulse. It is the area-minimal alternative to the ripple-carry adders in the Adders library and reuses the same half-adder cell.

---
 rtl/serial_add_ctrl.sv | 114 +++++++++++
 tb/tb_serial_add_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: a single full-adder cell (two half adders plus OR)
// stepped LSB first over a WIDTH-bit operand pair with a registered carry.

module half_adder (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);
   assign s = x ^ y;
   assign c = x & y;
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic [1:0]       state_dbg
);
   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic [WIDTH-1:0] sum_next;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             carry_next;
   logic             s_bit;
   logic             p;
   logic             g1;
   logic             g2;

   // Handshake: an operation is taken on a rising edge where start_valid and
   // start_ready are both high; start_ready is high only while idle.
   assign start_ready = (state == S_IDLE);
   assign state_dbg   = state;

   half_adder u_ha0 (.x(a_sh[0]), .y(b_sh[0]), .s(p),     .c(g1));
   half_adder u_ha1 (.x(p),       .y(carry),   .s(s_bit), .c(g2));
   assign carry_next = g1 | g2;

   // New sum bit enters at the MSB; after WIDTH steps bit 0 lands at the LSB.
   assign sum_next = WIDTH'({s_bit, sum_sh} >> 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         sum    <= '0;
         cout   <= 1'b0;
         cnt    <= '0;
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         carry  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_valid) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  carry  <= cin;
                  sum_sh <= '0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= S_RUN;
               end
            end
            S_RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               sum_sh <= sum_next;
               carry  <= carry_next;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  sum   <= sum_next;
                  cout  <= carry_next;
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: WIDTH=8 directed/random ops,
// plus exhaustive WIDTH=4 and WIDTH=1 instances.
`timescale 1ns/1ps
module tb_serial_add_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   logic       rst8 = 1'b1, sv8 = 1'b0, cin8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0, sum8;
   logic       sr8, busy8, done8, cout8;
   logic [1:0] st8;

   logic       rst4 = 1'b1, sv4 = 1'b0, cin4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0, sum4;
   logic       sr4, busy4, done4, cout4;
   logic [1:0] st4;

   logic       rst1 = 1'b1, sv1 = 1'b0, cin1 = 1'b0;
   logic [0:0] a1 = '0, b1 = '0, sum1;
   logic       sr1, busy1, done1, cout1;
   logic [1:0] st1;

   serial_add_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst8), .start_valid(sv8), .start_ready(sr8), .a(a8), .b(b8),
      .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .state_dbg(st8));
   serial_add_ctrl #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst4), .start_valid(sv4), .start_ready(sr4), .a(a4), .b(b4),
      .cin(cin4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .state_dbg(st4));
   serial_add_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst1), .start_valid(sv1), .start_ready(sr1), .a(a1), .b(b1),
      .cin(cin1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .state_dbg(st1));

   logic [8:0] exp_q8[$];
   logic [4:0] exp_q4[$];
   logic [1:0] exp_q1[$];
   int         acc_q8[$];
   int         acc_q4[$];
   int         acc_q1[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got timeout/unexpected event expected none (cycle %0d)", name, cyc);
   endtask

   // Monitors: pop the expected result whenever a done pulse appears.
   always @(negedge clk) begin
      if (done8 === 1'b1) begin
         if (exp_q8.size() == 0) fail("done8_unexpected");
         else begin
            chk("result8", {cout8, sum8}, exp_q8.pop_front());
            chk("latency8", cyc - acc_q8.pop_front() + 1, 9);
         end
      end
      if (done4 === 1'b1) begin
         if (exp_q4.size() == 0) fail("done4_unexpected");
         else begin
            chk("result4", {cout4, sum4}, exp_q4.pop_front());
            chk("latency4", cyc - acc_q4.pop_front() + 1, 5);
         end
      end
      if (done1 === 1'b1) begin
         if (exp_q1.size() == 0) fail("done1_unexpected");
         else begin
            chk("result1", {cout1, sum1}, exp_q1.pop_front());
            chk("latency1", cyc - acc_q1.pop_front() + 1, 2);
         end
      end
   end

   task automatic issue8(input logic [7:0] xa, input logic [7:0] xb, input logic xc);
      int n = 0;
      @(negedge clk);
      while (sr8 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      if (sr8 !== 1'b1) fail("ready8_timeout");
      else begin
         a8 = xa; b8 = xb; cin8 = xc; sv8 = 1'b1;
         exp_q8.push_back(9'(xa) + 9'(xb) + 9'(xc));
         acc_q8.push_back(cyc + 1);
         @(posedge clk);
         #1;
         sv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
   endtask

   task automatic issue4(input logic [3:0] xa, input logic [3:0] xb, input logic xc);
      int n = 0;
      @(negedge clk);
      while (sr4 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      if (sr4 !== 1'b1) fail("ready4_timeout");
      else begin
         a4 = xa; b4 = xb; cin4 = xc; sv4 = 1'b1;
         exp_q4.push_back(5'(xa) + 5'(xb) + 5'(xc));
         acc_q4.push_back(cyc + 1);
         @(posedge clk);
         #1;
         sv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
      end
   endtask

   task automatic issue1(input logic xa, input logic xb, input logic xc);
      int n = 0;
      @(negedge clk);
      while (sr1 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      if (sr1 !== 1'b1) fail("ready1_timeout");
      else begin
         a1 = xa; b1 = xb; cin1 = xc; sv1 = 1'b1;
         exp_q1.push_back(2'(xa) + 2'(xb) + 2'(xc));
         acc_q1.push_back(cyc + 1);
         @(posedge clk);
         #1;
         sv1 = 1'b0;
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q8.size() + exp_q4.size() + exp_q1.size()) != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if ((exp_q8.size() + exp_q4.size() + exp_q1.size()) != 0) begin
         fail("drain_timeout");
         exp_q8.delete(); acc_q8.delete();
         exp_q4.delete(); acc_q4.delete();
         exp_q1.delete(); acc_q1.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst8 = 1'b0; rst4 = 1'b0; rst1 = 1'b0;
      @(negedge clk);
      chk("rst_ready", sr8, 1);
      chk("rst_busy", busy8, 0);
      chk("rst_done", done8, 0);
      chk("rst_sum", sum8, 0);
      chk("rst_cout", cout8, 0);

      // First op: ready low / busy high for the whole RUN+DONE window.
      issue8(8'h00, 8'h00, 1'b0);
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         chk("op_ready_low", sr8, 0);
         chk("op_busy_high", busy8, 1);
      end
      @(negedge clk);
      chk("idle_ready", sr8, 1);
      chk("idle_busy", busy8, 0);
      drain();

      issue8(8'hFF, 8'h01, 1'b0);
      issue8(8'hFF, 8'hFF, 1'b1);
      issue8(8'h5A, 8'h33, 1'b0);
      drain();

      // start_valid held high with operands churning during the operation.
      chk("pre_held_ready", sr8, 1);
      a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; sv8 = 1'b1;
      exp_q8.push_back(9'h046);
      acc_q8.push_back(cyc + 1);
      @(posedge clk);
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         chk("held_ready_low", sr8, 0);
         chk("held_busy_high", busy8, 1);
         a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
      @(negedge clk);
      chk("reaccept_ready", sr8, 1);
      a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
      exp_q8.push_back(9'h100);
      acc_q8.push_back(cyc + 1);
      @(posedge clk);
      #1;
      sv8 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("sum_hold", sum8, 8'h46);
         chk("cout_hold", cout8, 0);
      end
      drain();

      // Abort on the 4th RUN cycle after leaving a nonzero result behind.
      issue8(8'h5A, 8'h33, 1'b0);
      drain();
      issue8(8'h11, 8'h22, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst8 = 1'b1;
      exp_q8.delete();
      acc_q8.delete();
      @(posedge clk);
      #1;
      rst8 = 1'b0;
      @(negedge clk);
      chk("abort_ready", sr8, 1);
      chk("abort_busy", busy8, 0);
      chk("abort_done", done8, 0);
      chk("abort_sum", sum8, 0);
      chk("abort_cout", cout8, 0);
      repeat (12) @(negedge clk);
      issue8(8'h0F, 8'h01, 1'b0);
      drain();

      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         issue8(8'($urandom), 8'($urandom), 1'($urandom));
      end
      drain();

      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            for (int c = 0; c < 2; c++)
               issue4(4'(i), 4'(j), 1'(c));
      drain();

      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++)
            for (int c = 0; c < 2; c++)
               issue1(1'(i), 1'(j), 1'(c));
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
